// File: rtl/insfetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from the icache and
// queues {word, pc, next_pc, compressed} for the decoder. Optional JAL target prediction
// is enabled by defining INSFETCH_JAL_PREDICT_EN.
module insfetch_unit #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          QUEUE_DEPTH_BITS = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic [31:0] flush_target_pc,
    output logic [31:0] read_addr,
    output logic        is_reading,
    input  logic [31:0] read_data,
    input  logic        is_ready,
    input  logic        icache_available,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_next_pc,
    output logic        ins_is_compressed,
    input  logic        ins_accept
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_BITS;
    localparam logic [QUEUE_DEPTH_BITS:0]   CNT_ONE = 1;
    localparam logic [QUEUE_DEPTH_BITS-1:0] PTR_ONE = 1;

    typedef enum logic {S_RUN, S_WAIT} state_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        comp;
    } entry_t;

    state_e                      state_q, state_d;
    logic [31:0]                 pc_q, pc_d;
    logic [QUEUE_DEPTH_BITS:0]   cnt_q, cnt_d;
    logic [QUEUE_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [QUEUE_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    entry_t                      mem_q [DEPTH];

    logic        active;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        fetch_comp;
    logic [31:0] fetch_next;
    entry_t      head;

    // Length decode of the word arriving from the icache this cycle.
    always_comb begin
        fetch_comp = (read_data[1:0] != 2'b11);
        fetch_next = pc_q + (fetch_comp ? 32'd2 : 32'd4);
`ifdef INSFETCH_JAL_PREDICT_EN
        if (!fetch_comp && read_data[6:0] == 7'b1101111)
            fetch_next = pc_q + {{11{read_data[31]}}, read_data[31], read_data[19:12],
                                 read_data[20], read_data[30:21], 1'b0};
`endif
    end

    // Count can reach DEPTH exactly, so its MSB alone marks a full queue.
    assign active     = rdy_in && !flush_pipline;
    assign fifo_full  = cnt_q[QUEUE_DEPTH_BITS];
    assign is_reading = rst_in && active && (state_q == S_RUN) && icache_available && !fifo_full;
    assign push       = active && is_ready && (is_reading || state_q == S_WAIT);
    assign pop        = active && ins_valid && ins_accept;
    assign read_addr  = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rdy_in) begin
            if (flush_pipline) begin
                pc_d     = flush_target_pc;
                cnt_d    = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                state_d  = S_RUN;
            end else begin
                if (push) begin
                    pc_d     = fetch_next;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    state_d  = S_RUN;
                end else if (is_reading) begin
                    state_d = S_WAIT;
                end
                if (pop)
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                case ({push, pop})
                    2'b10:   cnt_d = cnt_q + CNT_ONE;
                    2'b01:   cnt_d = cnt_q - CNT_ONE;
                    default: cnt_d = cnt_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: the outputs are masked while the queue is empty.
    always_ff @(posedge clk_in) begin
        if (push)
            mem_q[wr_ptr_q] <= '{word: read_data, pc: pc_q, next_pc: fetch_next, comp: fetch_comp};
    end

    assign head              = mem_q[rd_ptr_q];
    assign ins_valid         = (cnt_q != '0);
    assign ins_data          = ins_valid ? head.word    : 32'h0;
    assign ins_pc            = ins_valid ? head.pc      : 32'h0;
    assign ins_next_pc       = ins_valid ? head.next_pc : 32'h0;
    assign ins_is_compressed = ins_valid && head.comp;

endmodule

// File: tb/tb_insfetch_unit.sv
// Self-checking bench for insfetch_unit: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_insfetch_unit;

    localparam int QDB   = 2;
    localparam int DEPTH = 1 << QDB;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_pipline = 1'b0;
    logic [31:0] flush_target_pc = 32'h0;
    logic [31:0] read_data = 32'h0;
    logic        is_ready = 1'b0;
    logic        icache_available = 1'b1;
    logic        ins_accept = 1'b0;
    logic [31:0] read_addr, ins_data, ins_pc, ins_next_pc;
    logic        is_reading, ins_valid, ins_is_compressed;

    int n_checks = 0;
    int n_pass   = 0;

    insfetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH_BITS(QDB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .flush_pipline(flush_pipline), .flush_target_pc(flush_target_pc),
        .read_addr(read_addr), .is_reading(is_reading),
        .read_data(read_data), .is_ready(is_ready), .icache_available(icache_available),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
        .ins_next_pc(ins_next_pc), .ins_is_compressed(ins_is_compressed),
        .ins_accept(ins_accept)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Architectural next PC of a fetched word.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] imm;
        imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (w[1:0] != 2'b11) return pc + 32'd2;
`ifdef INSFETCH_JAL_PREDICT_EN
        if (w[6:0] == 7'h6F) return pc + imm;
`else
        if (imm == 32'hFFFF_FFFF) return pc; // never true: imm is even
`endif
        return pc + 32'd4;
    endfunction

    // Flush cycle to the given target; returns at the negedge starting cycle F+1.
    task automatic redirect(input logic [31:0] t);
        @(negedge clk_in);
        rdy_in = 1'b1; flush_pipline = 1'b1; flush_target_pc = t;
        is_ready = 1'b0; ins_accept = 1'b0; icache_available = 1'b1;
        @(negedge clk_in);
        flush_pipline = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        #2;
        n_checks++; if (read_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", read_addr); else n_pass++;
        n_checks++; if (is_reading !== 1'b0) $display("FAIL reset_reading got %b want 0", is_reading); else n_pass++;
        n_checks++; if (ins_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ins_valid); else n_pass++;
        n_checks++; if ({ins_data, ins_pc, ins_next_pc, ins_is_compressed} !== 97'h0)
            $display("FAIL reset_outs got %h/%h/%h want 0", ins_data, ins_pc, ins_next_pc); else n_pass++;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_hit_stream();
        is_ready = 1'b1; read_data = NOP; ins_accept = 1'b1; icache_available = 1'b1;
        #1;
        n_checks++; if (is_reading !== 1'b1 || read_addr !== 32'h0)
            $display("FAIL hit_req0 got %b/%h want 1/0", is_reading, read_addr); else n_pass++;
        n_checks++; if (ins_valid !== 1'b0) $display("FAIL hit_valid0 got %b want 0", ins_valid); else n_pass++;
        @(negedge clk_in); #1;
        n_checks++; if (read_addr !== 32'h4) $display("FAIL hit_addr1 got %h want 4", read_addr); else n_pass++;
        n_checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h0 || ins_next_pc !== 32'h4)
            $display("FAIL hit_head1 got %b/%h/%h want 1/0/4", ins_valid, ins_pc, ins_next_pc); else n_pass++;
        @(negedge clk_in); #1;
        n_checks++; if (read_addr !== 32'h8 || ins_pc !== 32'h4)
            $display("FAIL hit_addr2 got %h/%h want 8/4", read_addr, ins_pc); else n_pass++;
    endtask

    task automatic test_miss();
        redirect(32'h10);
        #1;
        n_checks++; if (is_reading !== 1'b1 || read_addr !== 32'h10)
            $display("FAIL miss_req got %b/%h want 1/10", is_reading, read_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in); #1;
            n_checks++; if (is_reading !== 1'b0 || read_addr !== 32'h10)
                $display("FAIL miss_wait%0d got %b/%h want 0/10", i, is_reading, read_addr); else n_pass++;
        end
        @(negedge clk_in);
        is_ready = 1'b1; read_data = 32'h00A0_0093;
        #1;
        n_checks++; if (is_reading !== 1'b0) $display("FAIL miss_fill_rd got %b want 0", is_reading); else n_pass++;
        @(negedge clk_in);
        is_ready = 1'b0;
        #1;
        n_checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h10 || ins_next_pc !== 32'h14 || ins_data !== 32'h00A0_0093)
            $display("FAIL miss_entry got %b/%h/%h/%h want 1/10/14/00a00093", ins_valid, ins_pc, ins_next_pc, ins_data); else n_pass++;
        n_checks++; if (read_addr !== 32'h14 || is_reading !== 1'b1)
            $display("FAIL miss_next got %h/%b want 14/1", read_addr, is_reading); else n_pass++;
    endtask

    task automatic test_compressed();
        redirect(32'h20);
        is_ready = 1'b1; read_data = 32'h0000_4501;
        #1;
        n_checks++; if (read_addr !== 32'h20) $display("FAIL comp_addr got %h want 20", read_addr); else n_pass++;
        @(negedge clk_in);
        is_ready = 1'b0; icache_available = 1'b0;
        #1;
        n_checks++; if (ins_is_compressed !== 1'b1 || ins_data[15:0] !== 16'h4501)
            $display("FAIL comp_flag got %b/%h want 1/4501", ins_is_compressed, ins_data[15:0]); else n_pass++;
        n_checks++; if (ins_next_pc !== 32'h22 || read_addr !== 32'h22)
            $display("FAIL comp_next got %h/%h want 22/22", ins_next_pc, read_addr); else n_pass++;
        icache_available = 1'b1;
    endtask

    task automatic test_backpressure();
        int pushes = 0;
        redirect(32'h100);
        is_ready = 1'b1; read_data = NOP; ins_accept = 1'b0;
        repeat (6) begin
            #1; if (is_reading) pushes++;
            @(negedge clk_in);
        end
        n_checks++; if (pushes != DEPTH) $display("FAIL bp_pushes got %0d want %0d", pushes, DEPTH); else n_pass++;
        #1;
        n_checks++; if (is_reading !== 1'b0 || ins_pc !== 32'h100)
            $display("FAIL bp_full got %b/%h want 0/100", is_reading, ins_pc); else n_pass++;
        ins_accept = 1'b1;
        @(negedge clk_in);
        ins_accept = 1'b0;
        #1;
        n_checks++; if (is_reading !== 1'b1 || read_addr !== 32'h110 || ins_pc !== 32'h104)
            $display("FAIL bp_pop got %b/%h/%h want 1/110/104", is_reading, read_addr, ins_pc); else n_pass++;
        @(negedge clk_in); #1;
        n_checks++; if (is_reading !== 1'b0) $display("FAIL bp_refull got %b want 0", is_reading); else n_pass++;
    endtask

    task automatic test_flush_wait();
        redirect(32'h200);
        #1;
        n_checks++; if (is_reading !== 1'b1) $display("FAIL fw_req got %b want 1", is_reading); else n_pass++;
        @(negedge clk_in);
        flush_pipline = 1'b1; flush_target_pc = 32'h80; is_ready = 1'b1; read_data = NOP;
        #1;
        n_checks++; if (is_reading !== 1'b0) $display("FAIL fw_flushrd got %b want 0", is_reading); else n_pass++;
        @(negedge clk_in);
        flush_pipline = 1'b0; is_ready = 1'b0;
        #1;
        n_checks++; if (ins_valid !== 1'b0 || read_addr !== 32'h80 || is_reading !== 1'b1)
            $display("FAIL fw_after got %b/%h/%b want 0/80/1", ins_valid, read_addr, is_reading); else n_pass++;
    endtask

    task automatic test_jal();
        logic [31:0] exp;
`ifdef INSFETCH_JAL_PREDICT_EN
        exp = 32'h50;
`else
        exp = 32'h44;
`endif
        redirect(32'h40);
        is_ready = 1'b1; read_data = 32'h0100_006F;
        @(negedge clk_in);
        is_ready = 1'b0; icache_available = 1'b0;
        #1;
        n_checks++; if (ins_pc !== 32'h40 || ins_next_pc !== exp || read_addr !== exp)
            $display("FAIL jal got %h/%h/%h want 40/%h/%h", ins_pc, ins_next_pc, read_addr, exp, exp); else n_pass++;
        icache_available = 1'b1;
    endtask

    task automatic test_rdy_low();
        redirect(32'h500);
        is_ready = 1'b1; read_data = NOP;
        @(negedge clk_in);
        rdy_in = 1'b0; flush_pipline = 1'b1; flush_target_pc = 32'h900; ins_accept = 1'b1;
        #1;
        n_checks++; if (is_reading !== 1'b0) $display("FAIL rdy_rd got %b want 0", is_reading); else n_pass++;
        @(negedge clk_in); #1;
        n_checks++; if (read_addr !== 32'h504 || ins_valid !== 1'b1 || ins_pc !== 32'h500)
            $display("FAIL rdy_hold got %h/%b/%h want 504/1/500", read_addr, ins_valid, ins_pc); else n_pass++;
        rdy_in = 1'b1; flush_pipline = 1'b0; ins_accept = 1'b0; is_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        redirect(32'h300);
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        n_checks++; if (read_addr !== 32'h0 || is_reading !== 1'b0 || ins_valid !== 1'b0)
            $display("FAIL arst got %h/%b/%b want 0/0/0", read_addr, is_reading, ins_valid); else n_pass++;
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        n_checks++; if (is_reading !== 1'b1 || read_addr !== 32'h0)
            $display("FAIL arst_req got %b/%h want 1/0", is_reading, read_addr); else n_pass++;
    endtask

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        c;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic [31:0] m_pc;
        logic        m_wait, exp_rd, do_push, do_pop;
        m_pc = 32'h0000_1000; m_wait = 1'b0;
        redirect(m_pc);
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy_in           = ($urandom_range(0, 9) != 0);
            flush_pipline    = ($urandom_range(0, 29) == 0);
            flush_target_pc  = {$urandom_range(0, 65535), 16'h0} | {16'h0, 15'($urandom), 1'b0};
            icache_available = ($urandom_range(0, 4) != 0);
            is_ready         = $urandom_range(0, 1) == 1;
            ins_accept       = ($urandom_range(0, 9) < 6);
            read_data        = $urandom;
            if ($urandom_range(0, 7) == 0) read_data[6:0] = 7'h6F;
            #1;
            exp_rd = rdy_in && !flush_pipline && !m_wait && icache_available && (q.size() < DEPTH);
            n_checks++; if (is_reading !== exp_rd || read_addr !== m_pc)
                $display("FAIL rnd_req c%0d got %b/%h want %b/%h", cyc, is_reading, read_addr, exp_rd, m_pc); else n_pass++;
            n_checks++; if (ins_valid !== (q.size() != 0))
                $display("FAIL rnd_valid c%0d got %b want %b", cyc, ins_valid, q.size() != 0); else n_pass++;
            if (q.size() != 0) begin
                e = q[0];
                n_checks++; if (ins_pc !== e.pc || ins_next_pc !== e.npc || ins_is_compressed !== e.c
                                || ins_data[15:0] !== e.w[15:0] || (!e.c && ins_data !== e.w))
                    $display("FAIL rnd_head c%0d got %h/%h/%b/%h want %h/%h/%b/%h", cyc,
                             ins_pc, ins_next_pc, ins_is_compressed, ins_data, e.pc, e.npc, e.c, e.w);
                else n_pass++;
            end
            if (rdy_in) begin
                if (flush_pipline) begin
                    m_pc = flush_target_pc; q.delete(); m_wait = 1'b0;
                end else begin
                    do_pop  = (q.size() != 0) && ins_accept;
                    do_push = is_ready && (exp_rd || m_wait);
                    if (do_pop) void'(q.pop_front());
                    if (do_push) begin
                        e.w = read_data; e.pc = m_pc; e.npc = ref_next(m_pc, read_data);
                        e.c = (read_data[1:0] != 2'b11);
                        q.push_back(e);
                        m_pc = e.npc; m_wait = 1'b0;
                    end else if (exp_rd) begin
                        m_wait = 1'b1;
                    end
                end
            end
            @(negedge clk_in);
        end
        rdy_in = 1'b1; flush_pipline = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hit_stream();
        test_miss();
        test_compressed();
        test_backpressure();
        test_flush_wait();
        test_jal();
        test_rdy_low();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/insfetch_unit.md
# insfetch_unit

Instruction fetch stage directly upstream of `InstructionCache`. It owns the program counter, issues one-address-at-a-time read requests to the icache and collects each returned 32-bit word in the cycle `is_ready` is asserted. It decodes the instruction length (RV32C aware) to advance the PC and buffers fetched instructions, with their PCs, in a small FIFO. The FIFO feeds the decoder through a valid/accept handshake. A pipeline flush redirects the PC and empties the FIFO.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `QUEUE_DEPTH_BITS`, default 2: FIFO depth is 2^QUEUE_DEPTH_BITS entries.

Ports (clock and reset first):
- `clk_in` in 1: single system clock; all state updates on its rising edge.
- `rst_in` in 1: reset; asynchronous, active-low.
- `rdy_in` in 1: global ready; when low, all state is frozen and `is_reading` is 0.
- `flush_pipline` in 1: redirect request.
- `flush_target_pc` in 32: new PC, sampled when `flush_pipline` is high.
- `read_addr` out 32: icache address; always equals current PC.
- `is_reading` out 1: icache request strobe.
- `read_data` in 32: icache word; valid only while `is_ready` is high.
- `is_ready` in 1: icache data strobe, combinational from the icache.
- `icache_available` in 1: icache not busy with a miss.
- `ins_valid` out 1: FIFO head valid.
- `ins_data` out 32: head instruction word; upper half is don't-care for compressed instructions.
- `ins_pc` out 32: head PC.
- `ins_next_pc` out 32: head predicted next PC.
- `ins_is_compressed` out 1: head is a 16-bit instruction.
- `ins_accept` in 1: decoder pops the head this cycle when `ins_valid` is high.

## Operation
- Reset values: `pc`=RESET_PC, FSM=RUN, count=0, `is_reading`=0, `ins_valid`=0, `ins_data`/`ins_pc`/`ins_next_pc`=0, `ins_is_compressed`=0.
- FSM RUN:
  - `is_reading` = `rdy_in` && !`flush_pipline` && `icache_available` && (count < depth).
  - If `is_reading` and `is_ready`, the word is pushed (hit), the PC advances and the FSM stays in RUN.
  - If `is_reading` and !`is_ready`, the FSM goes to WAIT.
  - `is_ready` without `is_reading` is ignored; the icache may raise it for stale addresses.
- FSM WAIT:
  - `is_reading`=0, and `pc`/`read_addr` are held.
  - On `is_ready`, the word is pushed, the PC advances and the FSM returns to RUN.
  - A FIFO slot is reserved for the outstanding word because issue required count < depth.
- Length decode: compressed = (word[1:0] != 2'b11). `len` is 2 if compressed, else 4.
- Next PC is pc + `len`, 32-bit wrap (32'hFFFF_FFFC + 4 = 0), unless the prediction feature below applies.
- FIFO:
  - A push stores {word, pc, next_pc, compressed}.
  - A pop occurs on `ins_valid` && `ins_accept`.
  - A simultaneous push and pop leaves count unchanged.
  - Read and write pointers wrap modulo depth.
  - Popping an empty FIFO has no effect.
- Flush (highest priority, when `rdy_in` is high):
  - `pc` <= `flush_target_pc`, count and pointers <= 0, FSM <= RUN.
  - Any `is_ready` data in the same cycle is dropped, and any outstanding miss is abandoned.
  - `is_reading`=0 in the flush cycle.
- `rdy_in` low: no pushes, pops, PC updates or FSM changes. A flush is not taken until `rdy_in` is high.
- Async reset mid-miss: returns to reset state immediately; the next request issues at RESET_PC.

## Timing
- Hit: request in cycle N, `ins_valid` at N+1. Sustained throughput is 1 instruction/cycle while the FIFO drains.
- Miss: `is_ready` in cycle M, `ins_valid` at M+1, next request no earlier than M+1.
- After a flush in cycle F, the first request at `flush_target_pc` is issued in F+1.
- FIFO outputs are registered-state driven and combinationally independent of `ins_accept`.

## Configuration
- `INSFETCH_JAL_PREDICT_EN` defined:
  - A non-compressed word with word[6:0]=7'b1101111 (JAL) sets next_pc = pc + sext({word[31], word[19:12], word[20], word[30:21], 1'b0}).
  - Fetch continues at that target.
- Undefined: next_pc is always pc + `len`, and JAL is treated as sequential.

## Test plan
- Reset with RESET_PC=0x0, icache hits every cycle, `ins_accept`=1 -> `read_addr` 0x0, 0x4, 0x8 on consecutive cycles; `ins_pc` 0x0 appears one cycle after the first request.
- Miss at 0x10, `is_ready` pulsed 5 cycles later with 0x00A00093 -> `is_reading` low while waiting; one entry with `ins_pc`=0x10, `ins_next_pc`=0x14.
- Word 0x00004501 (compressed) at 0x20 -> `ins_is_compressed`=1, next `read_addr`=0x22.
- `ins_accept`=0, hits every cycle, depth 4 -> exactly 4 pushes, then `is_reading`=0; one pop re-enables exactly one request.
- Flush to 0x80 while in WAIT with `is_ready` high in the same cycle -> FIFO empty, data dropped, next request at 0x80.
- With `INSFETCH_JAL_PREDICT_EN`: JAL word 0x0100006F at 0x40 -> `ins_next_pc`=0x50, next `read_addr`=0x50. Without the macro -> 0x44.
